bcd2bin_arbiter: RTL and testbench

- Shares one sequential BCD-to-binary converter (4 BCD digits in, W-bit binary out; start/ready/done_tick handshake) among NREQ requesters.
- Arbitrates round-robin, validates digits, sequences the converter's start/done handshake, and returns the result to the granted requester.
- Sits between the keypad/UART front ends and the single converter instance.

---
 rtl/bcd2bin_pkg.sv | 25 ++
 rtl/bcd2bin_arbiter_rr_pick.sv | 30 +++
 rtl/bcd2bin_arbiter.sv | 130 +++++++++++++
 tb/tb_bcd2bin_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/bcd2bin_pkg.sv
// Shared types and constants for the BCD-to-binary converter arbiter.
// Also holds the digit legality helper used by the CHECK state.
package bcd2bin_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHECK     = 3'd1,
        ISSUE     = 3'd2,
        WAIT_DONE = 3'd3,
        RESP      = 3'd4
    } state_t;

    localparam int BCD_MAX_DIGIT = 9;
    localparam int NUM_DIGITS    = 4;

    function automatic logic bcd_legal(input logic [15:0] digits);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digits[4*i +: 4] > 4'(BCD_MAX_DIGIT)) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd2bin_arbiter_rr_pick.sv
// Combinational round-robin select: first set request at or after ptr, modulo NREQ.
// Generic so other shared resources can reuse it.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   grant,
    output logic            valid
);

    logic [IW:0] idx;

    // Scan from the far end so the last hit written is the nearest to ptr.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = {1'b0, ptr} + (IW+1)'(i);
            if (idx >= (IW+1)'(NREQ)) idx = idx - (IW+1)'(NREQ);
            if (req[idx[IW-1:0]]) begin
                grant = idx[IW-1:0];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd2bin_arbiter.sv
// Round-robin arbiter sharing one sequential BCD-to-binary converter among NREQ requesters.
// state     | meaning
// IDLE      | waiting for a request; grants and latches digits
// CHECK     | rejects illegal digits, otherwise loads converter digits
// ISSUE     | waits for converter ready with done low, pulses cv_start
// WAIT_DONE | waits for done rising edge or timeout
// RESP      | rsp_valid pulse to the grant, advances the pointer
module bcd2bin_arbiter
    import bcd2bin_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 14,
    parameter int TMO  = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    input  logic [16*NREQ-1:0] bcd_in,
    output logic [NREQ-1:0]  rsp_valid,
    output logic [W-1:0]     rsp_bin,
    output logic             rsp_err,
    output logic             busy,
    output logic             cv_start,
    output logic [3:0]       cv_bcd0,
    output logic [3:0]       cv_bcd1,
    output logic [3:0]       cv_bcd2,
    output logic [3:0]       cv_bcd3,
    input  logic             cv_ready,
    input  logic             cv_done_tick,
    input  logic [W-1:0]     cv_bin
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TMO > 2) ? $clog2(TMO) : 1;

    state_t          state, state_nx;
    logic [IW-1:0]   ptr, grant_q, pick_idx;
    logic            pick_ok;
    logic [15:0]     dig_q;
    logic [CW-1:0]   tmo_cnt;
    logic            done_q, done_rise, timed_out, issue_ok;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .grant (pick_idx),
        .valid (pick_ok)
    );

    assign done_rise = cv_done_tick & ~done_q;
    assign timed_out = (tmo_cnt == CW'(TMO - 1));
    // A done still high from the previous conversion must not be mistaken for this one's.
    assign issue_ok  = cv_ready & ~cv_done_tick;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (pick_ok) state_nx = CHECK;
            CHECK:     state_nx = bcd_legal(dig_q) ? ISSUE : RESP;
            ISSUE:     if (issue_ok) state_nx = WAIT_DONE;
            WAIT_DONE: if (done_rise || timed_out) state_nx = RESP;
            RESP:      state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr       <= '0;
            grant_q   <= '0;
            dig_q     <= '0;
            tmo_cnt   <= '0;
            done_q    <= 1'b0;
            rsp_valid <= '0;
            rsp_bin   <= '0;
            rsp_err   <= 1'b0;
            cv_start  <= 1'b0;
            cv_bcd0   <= '0;
            cv_bcd1   <= '0;
            cv_bcd2   <= '0;
            cv_bcd3   <= '0;
        end else begin
            done_q    <= cv_done_tick;
            cv_start  <= 1'b0;
            rsp_valid <= '0;
            case (state)
                IDLE: if (pick_ok) begin
                    grant_q <= pick_idx;
                    dig_q   <= bcd_in[16*pick_idx +: 16];
                end
                CHECK: if (!bcd_legal(dig_q)) begin
                    rsp_bin   <= '0;
                    rsp_err   <= 1'b1;
                    rsp_valid <= NREQ'(1) << grant_q;
                end else begin
                    cv_bcd0 <= dig_q[3:0];
                    cv_bcd1 <= dig_q[7:4];
                    cv_bcd2 <= dig_q[11:8];
                    cv_bcd3 <= dig_q[15:12];
                end
                ISSUE: if (issue_ok) begin
                    cv_start <= 1'b1;
                    tmo_cnt  <= '0;
                end
                WAIT_DONE: begin
                    if (done_rise) begin
                        rsp_bin   <= cv_bin;
                        rsp_err   <= 1'b0;
                        rsp_valid <= NREQ'(1) << grant_q;
                    end else if (timed_out) begin
                        rsp_bin   <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= NREQ'(1) << grant_q;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RESP: ptr <= (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd2bin_arbiter.sv
// Directed bench for bcd2bin_arbiter with a behavioural converter model.
// Expected results are hand-computed constants per vector.
module tb_bcd2bin_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [63:0] bcd_in;
    logic [3:0]  rsp_valid;
    logic [13:0] rsp_bin;
    logic        rsp_err, busy, cv_start;
    logic [3:0]  cv_bcd0, cv_bcd1, cv_bcd2, cv_bcd3;
    logic        cv_ready, cv_done_tick;
    logic [13:0] cv_bin;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0;
    int start_cnt = 0, start_cyc = 0, done_rise_cyc = 0, done_fall_cyc = 0, rsp_cnt = 0;
    int hold_cycles = 1;
    bit never_done = 0, bad_start = 0;
    int m_lat = 0, m_hold = 0, m_val = 0;

    bcd2bin_arbiter #(.NREQ(4), .W(14), .TMO(16)) dut (
        .clk(clk), .reset(reset), .req(req), .bcd_in(bcd_in),
        .rsp_valid(rsp_valid), .rsp_bin(rsp_bin), .rsp_err(rsp_err), .busy(busy),
        .cv_start(cv_start), .cv_bcd0(cv_bcd0), .cv_bcd1(cv_bcd1),
        .cv_bcd2(cv_bcd2), .cv_bcd3(cv_bcd3), .cv_ready(cv_ready),
        .cv_done_tick(cv_done_tick), .cv_bin(cv_bin)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;
    always @(negedge clk) if (rsp_valid != 0) rsp_cnt = rsp_cnt + 1;

    // Converter model: 3-cycle conversion, done held for hold_cycles, reset with the arbiter.
    initial begin
        cv_ready = 1'b1; cv_done_tick = 1'b0; cv_bin = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                cv_ready = 1'b1; cv_done_tick = 1'b0; m_lat = 0; m_hold = 0;
            end else if (cv_start) begin
                start_cnt = start_cnt + 1;
                start_cyc = cyc;
                if (cv_done_tick || !cv_ready) bad_start = 1;
                m_val = int'(cv_bcd3)*1000 + int'(cv_bcd2)*100 + int'(cv_bcd1)*10 + int'(cv_bcd0);
                cv_ready = never_done;
                m_lat = never_done ? 0 : 3;
            end else if (m_lat > 0) begin
                m_lat = m_lat - 1;
                if (m_lat == 0) begin
                    cv_bin = 14'(m_val); cv_done_tick = 1'b1; cv_ready = 1'b1;
                    m_hold = hold_cycles; done_rise_cyc = cyc;
                end
            end else if (m_hold > 0) begin
                m_hold = m_hold - 1;
                if (m_hold == 0) begin
                    cv_done_tick = 1'b0; done_fall_cyc = cyc;
                end
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic wait_rsp(input string tag, input int budget, output logic [3:0] v,
                            output logic [13:0] b, output logic e, output int c);
        bit seen;
        seen = 0; v = '0; b = '0; e = 1'b0; c = 0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (rsp_valid != 0) begin
                seen = 1; v = rsp_valid; b = rsp_bin; e = rsp_err; c = cyc;
            end
        end
        check_val({tag, "_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic expect_rsp(input string tag, input int budget, input logic [3:0] ev,
                              input int eb, input logic ee, output int c);
        logic [3:0] v; logic [13:0] b; logic e;
        wait_rsp(tag, budget, v, b, e, c);
        check_val({tag, "_valid"}, 32'(v), 32'(ev));
        check_val({tag, "_bin"},   32'(b), 32'(eb));
        check_val({tag, "_err"},   32'(e), 32'(ee));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=%0d exp=%0d", cyc, 0);
        $fatal(1, "watchdog");
    end

    initial begin
        int rq, c, n0, nr;
        bit st;
        reset = 1'b1; req = '0; bcd_in = '0;
        repeat (3) @(negedge clk);
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_valid", 32'(rsp_valid), 0);
        check_val("rst_bin", 32'(rsp_bin), 0);
        check_val("rst_err", 32'(rsp_err), 0);
        check_val("rst_start", 32'(cv_start), 0);
        check_val("rst_bcd", 32'({cv_bcd3, cv_bcd2, cv_bcd1, cv_bcd0}), 0);
        reset = 1'b0;

        // single legal request, latency checks
        @(negedge clk);
        bcd_in[15:0] = 16'h1234; req = 4'b0001; rq = cyc;
        expect_rsp("t1", 40, 4'b0001, 1234, 1'b0, c);
        req = '0;
        check_val("t1_start_lat", 32'(start_cyc - rq), 3);
        check_val("t1_rsp_lat", 32'(c - done_rise_cyc), 1);

        // simultaneous requests from pointer 0, then pointer-at-3 ordering
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        bcd_in[15:0] = 16'h9999; bcd_in[47:32] = 16'h0000; req = 4'b0101;
        expect_rsp("t2a", 40, 4'b0001, 9999, 1'b0, c);
        req[0] = 1'b0;
        expect_rsp("t2b", 40, 4'b0100, 0, 1'b0, c);
        req[2] = 1'b0;
        bcd_in[63:48] = 16'h0057; bcd_in[15:0] = 16'h0100; req = 4'b1001;
        expect_rsp("t2c", 40, 4'b1000, 57, 1'b0, c);
        req[3] = 1'b0;
        expect_rsp("t2d", 40, 4'b0001, 100, 1'b0, c);
        req = '0;

        // illegal digit: error response without touching the converter
        n0 = start_cnt;
        bcd_in[31:16] = 16'h12A4; req = 4'b0010;
        expect_rsp("t3", 40, 4'b0010, 0, 1'b1, c);
        req = '0;
        check_val("t3_no_start", 32'(start_cnt), 32'(n0));

        // long done pulse with back-to-back requests
        hold_cycles = 50; n0 = start_cnt;
        bcd_in[15:0] = 16'h0815; bcd_in[31:16] = 16'h4321; req = 4'b0011;
        expect_rsp("t4a", 200, 4'b0001, 815, 1'b0, c);
        req[0] = 1'b0;
        expect_rsp("t4b", 300, 4'b0010, 4321, 1'b0, c);
        req = '0; hold_cycles = 1;
        check_val("t4_bad_start", 32'(bad_start), 0);
        check_val("t4_starts", 32'(start_cnt), 32'(n0 + 2));
        check_val("t4_start_after_fall", 32'(start_cyc > done_fall_cyc), 1);

        // converter never finishes
        never_done = 1;
        bcd_in[47:32] = 16'h0001; req = 4'b0100;
        expect_rsp("t5", 200, 4'b0100, 0, 1'b1, c);
        req = '0;
        check_val("t5_tmo_lat", 32'(c - start_cyc), 16);

        // reset while waiting for done
        bcd_in[15:0] = 16'h0042; req = 4'b0001;
        st = 0;
        for (int k = 0; k < 20 && !st; k++) begin
            @(negedge clk);
            if (cv_start) st = 1;
        end
        check_val("t6_started", 32'(st), 1);
        repeat (3) @(negedge clk);
        nr = rsp_cnt;
        reset = 1'b1; req = '0;
        @(negedge clk);
        check_val("t6_busy", 32'(busy), 0);
        check_val("t6_start", 32'(cv_start), 0);
        check_val("t6_bcd", 32'({cv_bcd3, cv_bcd2, cv_bcd1, cv_bcd0}), 0);
        check_val("t6_err", 32'(rsp_err), 0);
        check_val("t6_valid", 32'(rsp_valid), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0; never_done = 0;
        repeat (3) @(negedge clk);
        check_val("t6_no_rsp", 32'(rsp_cnt), 32'(nr));
        req = 4'b0001;
        expect_rsp("t6_after", 40, 4'b0001, 42, 1'b0, c);
        req = '0;

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
